// File: rtl/dlp_pkg.sv
// -----------------------------------------------------------------------------
// dlp_pkg
// Shared definitions for the dot-product datapath: lane geometry of the
// 4-lane, 16-bit inner-product unit, the lane data type, the operand
// sequencer FSM states and a helper to slice one lane out of an SRAM word.
// -----------------------------------------------------------------------------
package dlp_pkg;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int RES_W  = 32;

  // One signed operand lane as seen by the inner-product unit.
  typedef logic signed [DATA_W-1:0] lane_t;

  // Sequencer job states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Lane idx of a packed SRAM word (lane i = bits [16i+15:16i]).
  function automatic lane_t lane_of(input logic [LANES*DATA_W-1:0] word,
                                    input int                      idx);
    return word[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/ip_result_accumulator.sv
// -----------------------------------------------------------------------------
// ip_result_accumulator
// Collects the inner-product unit's 32-bit partial results for one job.
// The first sampled result of a job is the unit's stale output (it reflects
// operands captured before this job) and is dropped; every later sample is
// sign-extended to ACC_W and added with wrap-around.
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   i_clear     start of a job: zero the sum and re-arm the stale skip
//   i_sample    i_result holds a result to consume this cycle
//   i_result    signed 32-bit result of the inner-product unit
//   o_acc       running (and, at job end, final) signed sum
// -----------------------------------------------------------------------------
module ip_result_accumulator
  import dlp_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_sample,
  input  logic signed [RES_W-1:0] i_result,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [ACC_W-1:0] r_acc;
  logic                    r_skip;
  logic signed [ACC_W-1:0] w_ext;

  // Widening a signed value sign-extends it.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [RES_W-1:0] v);
    return ACC_W'(v);
  endfunction

  assign w_ext = sext(i_result);

  // Accumulator and stale-result skip flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_skip <= 1'b1;
    end else if (i_clear) begin
      r_acc  <= '0;
      r_skip <= 1'b1;
    end else if (i_sample) begin
      if (r_skip) begin
        r_skip <= 1'b0;
      end else begin
        r_acc <= r_acc + w_ext;
      end
    end else begin
      r_acc  <= r_acc;
      r_skip <= r_skip;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/ip_dot_sequencer.sv
// -----------------------------------------------------------------------------
// ip_dot_sequencer
// Operand sequencer for the 4-lane inner-product unit. A job of G groups
// reads G words from each operand SRAM (same offset in lockstep), streams the
// returned words into the unit, appends one all-zero flush beat so the last
// group's product is pushed out, and accumulates the unit's results into a
// wide sum returned over a valid/ready handshake.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   i_start, i_vec_len             job request and group count (IDLE only)
//   i_act_base, i_wgt_base         first word address of each operand
//   o_busy                         any state other than IDLE
//   o_*_rd_en, o_*_rd_addr         SRAM read port (data returns next cycle)
//   i_*_rd_data                    SRAM read data, 4 signed 16-bit lanes
//   o_ip_enable                    inner-product unit enable
//   o_ip_activations, o_ip_weights operands, zero whenever o_ip_enable=0
//   i_ip_result                    inner-product unit result register
//   o_out_valid, i_out_ready       result handshake
//   o_out_data                     accumulated dot product
// -----------------------------------------------------------------------------
module ip_dot_sequencer
  import dlp_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10,
  parameter int ACC_W  = 48
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic [LEN_W-1:0]          i_vec_len,
  input  logic [ADDR_W-1:0]         i_act_base,
  input  logic [ADDR_W-1:0]         i_wgt_base,
  output logic                      o_busy,
  output logic                      o_act_rd_en,
  output logic                      o_wgt_rd_en,
  output logic [ADDR_W-1:0]         o_act_rd_addr,
  output logic [ADDR_W-1:0]         o_wgt_rd_addr,
  input  logic [LANES*DATA_W-1:0]   i_act_rd_data,
  input  logic [LANES*DATA_W-1:0]   i_wgt_rd_data,
  output logic                      o_ip_enable,
  output lane_t                     o_ip_activations [0:LANES-1],
  output lane_t                     o_ip_weights     [0:LANES-1],
  input  logic signed [RES_W-1:0]   i_ip_result,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic signed [ACC_W-1:0]   o_out_data
);

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;

  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_act_addr;
  logic [ADDR_W-1:0]   r_wgt_addr;
  logic [LEN_W-1:0]    r_remaining;   // reads still to issue after the current one
  logic                r_data_vld;    // SRAM data is on the read ports this cycle
  logic                r_flush_vld;   // zero-operand flush beat this cycle
  logic                r_res_vld;     // i_ip_result reflects an enabled edge

  logic signed [ACC_W-1:0] w_acc;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and job-accept decode.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          if (i_vec_len == '0) begin
            w_next = DONE;
          end else begin
            w_next = RUN;
          end
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        // r_remaining==0 means this cycle issues the last read.
        if (r_remaining == '0) begin
          w_next = DRAIN;
        end else begin
          w_next = RUN;
        end
      end
      DRAIN: begin
        // With no data or flush beat in flight, the last result lands in
        // the accumulator at the end of this cycle.
        if (!r_data_vld && !r_flush_vld) begin
          w_next = DONE;
        end else begin
          w_next = DRAIN;
        end
      end
      DONE: begin
        if (i_out_ready) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Read issue: group counter, lockstep address generation, read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en     <= 1'b0;
      r_act_addr  <= '0;
      r_wgt_addr  <= '0;
      r_remaining <= '0;
    end else if (w_accept && (i_vec_len != '0)) begin
      r_rd_en     <= 1'b1;
      r_act_addr  <= i_act_base;
      r_wgt_addr  <= i_wgt_base;
      r_remaining <= i_vec_len - LEN_W'(1);
    end else if ((r_state == RUN) && (r_remaining != '0)) begin
      r_rd_en     <= 1'b1;
      r_act_addr  <= r_act_addr + ADDR_W'(1);
      r_wgt_addr  <= r_wgt_addr + ADDR_W'(1);
      r_remaining <= r_remaining - LEN_W'(1);
    end else begin
      r_rd_en     <= 1'b0;
      r_act_addr  <= r_act_addr;
      r_wgt_addr  <= r_wgt_addr;
      r_remaining <= r_remaining;
    end
  end

  // Valid pipeline: data stage, flush beat, result-available stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_vld  <= 1'b0;
      r_flush_vld <= 1'b0;
      r_res_vld   <= 1'b0;
    end else begin
      r_data_vld  <= r_rd_en;
      // Reads are contiguous, so a data beat with no read behind it is the last.
      r_flush_vld <= r_data_vld & ~r_rd_en;
      r_res_vld   <= r_data_vld | r_flush_vld;
    end
  end

  // Operand pass-through, forced to zero outside data beats.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (r_data_vld) begin
        o_ip_activations[i] = lane_of(i_act_rd_data, i);
        o_ip_weights[i]     = lane_of(i_wgt_rd_data, i);
      end else begin
        o_ip_activations[i] = '0;
        o_ip_weights[i]     = '0;
      end
    end
  end

  ip_result_accumulator #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_accept),
    .i_sample (r_res_vld),
    .i_result (i_ip_result),
    .o_acc    (w_acc)
  );

  assign o_busy        = (r_state != IDLE);
  assign o_out_valid   = (r_state == DONE);
  assign o_act_rd_en   = r_rd_en;
  assign o_wgt_rd_en   = r_rd_en;
  assign o_act_rd_addr = r_act_addr;
  assign o_wgt_rd_addr = r_wgt_addr;
  assign o_ip_enable   = r_data_vld | r_flush_vld;
  // The accumulator is cleared at accept and frozen after DONE, so it
  // directly provides the held result in DONE and IDLE.
  assign o_out_data    = w_acc;

endmodule

// File: tb/tb_ip_dot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ip_dot_sequencer
// Directed bench: two operand SRAM models and an inner-product unit model
// surround the sequencer. A cycle-level reference derived from the job
// timing rules (cycle offsets from accept) is compared with every output on
// every cycle; directed jobs also pin hand-computed sums and latencies.
// -----------------------------------------------------------------------------
module tb_ip_dot_sequencer;
  import dlp_pkg::*;

  localparam int  ADDR_W = 10;
  localparam int  LEN_W  = 10;
  localparam int  ACC_W  = 48;
  localparam int  DEPTH  = 1024;
  localparam longint MASK48 = 64'h0000_FFFF_FFFF_FFFF;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [LEN_W-1:0]         vec_len;
  logic [ADDR_W-1:0]        act_base, wgt_base;
  logic                     busy, act_rd_en, wgt_rd_en;
  logic [ADDR_W-1:0]        act_rd_addr, wgt_rd_addr;
  logic [63:0]              act_rd_data = '0, wgt_rd_data = '0;
  logic                     ip_enable;
  lane_t                    ip_act [0:3];
  lane_t                    ip_wgt [0:3];
  logic signed [31:0]       ip_result;
  logic                     out_valid, out_ready;
  logic signed [ACC_W-1:0]  out_data;

  logic [63:0] act_mem [0:DEPTH-1];
  logic [63:0] wgt_mem [0:DEPTH-1];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  ip_dot_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_vec_len(vec_len),
    .i_act_base(act_base), .i_wgt_base(wgt_base), .o_busy(busy),
    .o_act_rd_en(act_rd_en), .o_wgt_rd_en(wgt_rd_en),
    .o_act_rd_addr(act_rd_addr), .o_wgt_rd_addr(wgt_rd_addr),
    .i_act_rd_data(act_rd_data), .i_wgt_rd_data(wgt_rd_data),
    .o_ip_enable(ip_enable), .o_ip_activations(ip_act), .o_ip_weights(ip_wgt),
    .i_ip_result(ip_result), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [15:0] la, lb, lc, ld;
    la = a[15:0]; lb = b[15:0]; lc = c[15:0]; ld = d[15:0];
    return {ld, lc, lb, la};
  endfunction

  // 32-bit wrapping dot product of two 4-lane words.
  function automatic int dot32(input logic [63:0] a, input logic [63:0] w);
    int s = 0;
    logic signed [15:0] la, lw;
    for (int i = 0; i < 4; i++) begin
      la = a[16*i +: 16];
      lw = w[16*i +: 16];
      s = s + int'(la) * int'(lw);
    end
    return s;
  endfunction

  function automatic longint job_sum(input int g, input int ab, input int wb);
    longint s = 0;
    for (int k = 0; k < g; k++)
      s = s + longint'(dot32(act_mem[(ab + k) % DEPTH], wgt_mem[(wb + k) % DEPTH]));
    return s & MASK48;
  endfunction

  // Synchronous-read operand SRAMs.
  always @(posedge clk) begin
    if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
    if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
  end

  // Inner-product unit: result = dot of previously captured operands.
  logic [63:0] cap_a, cap_w;
  always @(posedge clk) begin
    if (reset) begin
      cap_a <= '0; cap_w <= '0; ip_result <= '0;
    end else if (ip_enable) begin
      ip_result <= dot32(cap_a, cap_w);
      cap_a <= {ip_act[3], ip_act[2], ip_act[1], ip_act[0]};
      cap_w <= {ip_wgt[3], ip_wgt[2], ip_wgt[1], ip_wgt[0]};
    end
  end

  // Reference model: job phase, cycle offset from accept, expected sum.
  logic   chk_en = 1'b0;
  logic   m_job = 1'b0;
  logic   m_addr_zero = 1'b1;
  int     m_t = 0, m_G = 0, m_ab = 0, m_wb = 0;
  longint m_sum = 0, m_last = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_job <= 1'b0; m_last <= 0; m_addr_zero <= 1'b1; chk_en <= 1'b1;
    end else if (!m_job) begin
      if (start) begin
        m_job <= 1'b1; m_t <= 1; m_G <= int'(vec_len);
        m_ab <= int'(act_base); m_wb <= int'(wgt_base);
        m_sum <= job_sum(int'(vec_len), int'(act_base), int'(wgt_base));
        if (vec_len != '0) m_addr_zero <= 1'b0;
      end
    end else begin
      if (m_t >= ((m_G == 0) ? 1 : m_G + 4) && out_ready) begin
        m_job <= 1'b0; m_last <= m_sum;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin : cmp
    logic e_busy, e_rd, e_beat, e_en, e_ov;
    logic signed [15:0] ea, ew;
    int t;
    if (chk_en) begin
      t = m_t;
      if (m_job) begin
        e_busy = 1'b1;
        e_rd   = (t >= 1) && (t <= m_G);
        e_beat = (t >= 2) && (t <= m_G + 1);
        e_en   = (m_G != 0) && (t >= 2) && (t <= m_G + 2);
        e_ov   = (t >= ((m_G == 0) ? 1 : m_G + 4));
      end else begin
        e_busy = 1'b0; e_rd = 1'b0; e_beat = 1'b0; e_en = 1'b0; e_ov = 1'b0;
      end
      check("busy", 64'(busy), 64'(e_busy));
      check("act_rd_en", 64'(act_rd_en), 64'(e_rd));
      check("wgt_rd_en", 64'(wgt_rd_en), 64'(e_rd));
      if (e_rd) begin
        check("act_rd_addr", 64'(act_rd_addr), 64'((m_ab + t - 1) % DEPTH));
        check("wgt_rd_addr", 64'(wgt_rd_addr), 64'((m_wb + t - 1) % DEPTH));
      end else if (!m_job && m_addr_zero) begin
        check("act_rd_addr_rst", 64'(act_rd_addr), 64'(0));
        check("wgt_rd_addr_rst", 64'(wgt_rd_addr), 64'(0));
      end
      check("ip_enable", 64'(ip_enable), 64'(e_en));
      for (int i = 0; i < 4; i++) begin
        if (e_beat) begin
          ea = act_mem[(m_ab + t - 2) % DEPTH][16*i +: 16];
          ew = wgt_mem[(m_wb + t - 2) % DEPTH][16*i +: 16];
        end else begin
          ea = '0; ew = '0;
        end
        check("ip_act", 64'(ip_act[i]), 64'(ea));
        check("ip_wgt", 64'(ip_wgt[i]), 64'(ew));
      end
      check("out_valid", 64'(out_valid), 64'(e_ov));
      if (e_ov) check("out_data", {16'd0, out_data}, m_sum);
      else if (!m_job) check("out_data_idle", {16'd0, out_data}, m_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; current cycle is then the first valid one.
  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    if (!out_valid) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout cycle %0d: got out_valid 0 expected 1", nm, cyc);
    end
  endtask

  task automatic run_job(input string nm, input int g, input int ab, input int wb,
                         input longint exp);
    int c0;
    tick();
    start = 1'b1; vec_len = LEN_W'(g); act_base = ADDR_W'(ab); wgt_base = ADDR_W'(wb);
    c0 = cyc;
    tick();
    start = 1'b0;
    wait_valid(nm);
    check({nm, "_lat"}, 64'(cyc - c0), 64'((g == 0) ? 1 : g + 4));
    check({nm, "_sum"}, 64'(out_data), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin act_mem[i] = '0; wgt_mem[i] = '0; end
    act_mem[10'h000] = pack4(1, 2, 3, 4);
    wgt_mem[10'h000] = pack4(5, 6, 7, 8);
    for (int k = 0; k < 3; k++) begin
      act_mem[10'h010 + k] = pack4(k + 1, k + 1, k + 1, k + 1);
      wgt_mem[10'h020 + k] = pack4(1, 1, 1, 1);
    end
    for (int k = 0; k < 2; k++) begin
      act_mem[10'h030 + k] = pack4(-3, -3, -3, -3);
      wgt_mem[10'h040 + k] = pack4(7, 7, 7, 7);
    end
    act_mem[10'h050] = pack4(-32768, -32768, -32768, -32768);
    wgt_mem[10'h060] = pack4(-32768, -32768, -32768, -32768);
    act_mem[10'h051] = pack4(1, 1, 1, 1);
    wgt_mem[10'h061] = pack4(1, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      act_mem[10'h070 + k] = pack4(k, -k, 2 * k, 3);
      wgt_mem[10'h070 + k] = pack4(1, 2, 3, k);
    end
    act_mem[10'h080] = pack4(1, 1, 1, 1);
    wgt_mem[10'h090] = pack4(2, 2, 2, 2);

    reset = 1'b1; start = 1'b0; vec_len = '0; act_base = '0; wgt_base = '0;
    out_ready = 1'b1;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    reset = 1'b0;

    run_job("g1", 1, 10'h000, 10'h000, 64'(70));
    run_job("g3", 3, 10'h010, 10'h020, 64'(24));
    run_job("neg", 2, 10'h030, 10'h040, -64'sd168);
    run_job("g0", 0, 10'h000, 10'h000, 64'(0));
    run_job("wrap", 2, 10'h050, 10'h060, 64'(4));

    // Held result under back-pressure; start pulses must not launch reads.
    tick();
    start = 1'b1; vec_len = LEN_W'(1); act_base = '0; wgt_base = '0; out_ready = 1'b0;
    tick();
    start = 1'b0;
    wait_valid("stall");
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 1);
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_data", 64'(out_data), 64'(70));
      tick();
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    check("handoff_idle_busy", 64'(busy), 64'(0));
    tick();
    check("next_accept_busy", 64'(busy), 64'(1));
    check("next_accept_rd", 64'(act_rd_en), 64'(1));
    start = 1'b0;
    wait_valid("after_stall");
    check("after_stall_sum", 64'(out_data), 64'(70));

    // Reset in cycle 3 of a long job.
    tick();
    start = 1'b1; vec_len = LEN_W'(8); act_base = 10'h070; wgt_base = 10'h070;
    tick(); start = 1'b0;
    tick();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_rd_en", 64'(act_rd_en), 64'(0));
    check("mid_rst_rd_addr", 64'(act_rd_addr), 64'(0));
    check("mid_rst_ip_en", 64'(ip_enable), 64'(0));
    check("mid_rst_data", 64'(out_data), 64'(0));
    run_job("post_rst", 1, 10'h080, 10'h090, 64'(8));

    tick(); tick(); tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
